// File: rtl/dac_spi_receiver_pkg.sv
// rtl/dac_spi_receiver_pkg.sv - shared frame layout, FSM states and channel type for the DAC link receiver
//
// Purpose: definitions shared by the DAC link receiver files (frame width,
//          code width, frame bit indices, FSM state encoding, channel record).
// Ports:   none (package).
package dac_spi_receiver_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_W     = 12;
  localparam int AB_BIT     = 15;   // 1 = channel B
  localparam int SHDN_BIT   = 12;   // 1 = channel active
  // Bit counter must reach FRAME_BITS+1 so over-long frames are distinguishable.
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic              on;
    logic [DATA_W-1:0] code;
  } chan_t;

  // A shut-down channel always presents a zero code.
  function automatic logic [DATA_W-1:0] gated_code(input chan_t c);
    return c.on ? c.code : '0;
  endfunction

endpackage

// File: rtl/dac_spi_receiver_if.sv
// rtl/dac_spi_receiver_if.sv - link pins and decoded outputs of the DAC link receiver
//
// Purpose: bundles the four serial link pins and the decoded DAC outputs.
// Ports (signals):
//   spi_csn, spi_sclk, spi_mosi, spi_latchn  link pins (master drives)
//   dac_a, dac_b [DATA_W]                    decoded channel codes
//   dac_a_on, dac_b_on                       channel active flags
//   update, frame_err                        one-cycle status pulses
// Modports: master = link driver / observer, slave = receiver.
interface dac_spi_receiver_if;
  import dac_spi_receiver_pkg::*;

  logic              spi_csn;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_latchn;
  logic [DATA_W-1:0] dac_a;
  logic [DATA_W-1:0] dac_b;
  logic              dac_a_on;
  logic              dac_b_on;
  logic              update;
  logic              frame_err;

  modport master (
    output spi_csn, spi_sclk, spi_mosi, spi_latchn,
    input  dac_a, dac_b, dac_a_on, dac_b_on, update, frame_err
  );

  modport slave (
    input  spi_csn, spi_sclk, spi_mosi, spi_latchn,
    output dac_a, dac_b, dac_a_on, dac_b_on, update, frame_err
  );

endinterface

// File: rtl/dac_spi_receiver_sync_edge.sv
// rtl/dac_spi_receiver_sync_edge.sv - pin synchroniser with registered rise/fall pulses
//
// Purpose: brings one asynchronous pin into the clk domain through
//          SYNC_STAGES flops and flags its edges.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   din         asynchronous pin
//   level       synchronised level, time-aligned with rise/fall
//   rise, fall  one-cycle edge pulses
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT        = 1'b0   // idle level of the pin, avoids a false edge after reset
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{INIT}};
      level  <= INIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
      fall   <= ~sync_q[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/dac_spi_receiver.sv
// rtl/dac_spi_receiver.sv - decodes MCP4922-style DAC link frames into per-channel codes
//
// Purpose: oversamples csn/sclk/mosi/latchn, shifts 16-bit frames MSB first,
//          commits good frames to a per-channel pending register and transfers
//          the pending registers to the outputs on a latchn fall.
// Ports:
//   clk    system clock (>= 4x sclk)
//   reset  asynchronous, active-high
//   bus    dac_spi_receiver_if.slave: link pins in, dac_a/dac_b/dac_*_on,
//          update and frame_err out
// Configuration: DAC_RX_AUTOLATCH_EN - when defined, latchn is ignored and each
//          good frame is transferred to its channel output one cycle after commit.
module dac_spi_receiver
  import dac_spi_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  dac_spi_receiver_if.slave bus
);

  logic csn_rise, csn_fall, sclk_rise, mosi_lvl, latchn_fall;
  logic unused_csn_lvl, unused_sclk_lvl, unused_sclk_fall;
  logic unused_mosi_rise, unused_mosi_fall, unused_latchn_lvl, unused_latchn_rise;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_csn (
    .clk(clk), .reset(reset), .din(bus.spi_csn),
    .level(unused_csn_lvl), .rise(csn_rise), .fall(csn_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .din(bus.spi_sclk),
    .level(unused_sclk_lvl), .rise(sclk_rise), .fall(unused_sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .din(bus.spi_mosi),
    .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_latchn (
    .clk(clk), .reset(reset), .din(bus.spi_latchn),
    .level(unused_latchn_lvl), .rise(unused_latchn_rise), .fall(latchn_fall)
  );

  state_t                state;
  logic [FRAME_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  chan_t                 pend_a, pend_b;
  chan_t                 pend_a_nxt, pend_b_nxt;
  chan_t                 new_chan;
  logic                  good_commit, bad_frame;
  logic                  xfer_a, xfer_b;
  logic [DATA_W-1:0]     dac_a_q, dac_b_q;
  logic                  dac_a_on_q, dac_b_on_q, update_q, frame_err_q;

  assign new_chan = '{on: shift_q[SHDN_BIT], code: shift_q[DATA_W-1:0]};

  // The commit is resolved combinationally so a transfer in the same cycle
  // already sees the frame that just ended.
  always_comb begin
    good_commit = 1'b0;
    bad_frame   = 1'b0;
    pend_a_nxt  = pend_a;
    pend_b_nxt  = pend_b;
    if (state == SHIFT && csn_rise) begin
      if (cnt_q == CNT_W'(FRAME_BITS)) begin
        good_commit = 1'b1;
        if (shift_q[AB_BIT]) pend_b_nxt = new_chan;
        else                 pend_a_nxt = new_chan;
      end else begin
        bad_frame = 1'b1;
      end
    end
  end

`ifdef DAC_RX_AUTOLATCH_EN
  logic auto_a_q, auto_b_q;
  logic unused_latchn_fall;

  assign unused_latchn_fall = latchn_fall;
  assign xfer_a = auto_a_q;
  assign xfer_b = auto_b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_a_q <= 1'b0;
      auto_b_q <= 1'b0;
    end else begin
      auto_a_q <= good_commit & ~shift_q[AB_BIT];
      auto_b_q <= good_commit &  shift_q[AB_BIT];
    end
  end
`else
  assign xfer_a = latchn_fall;
  assign xfer_b = latchn_fall;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      pend_a      <= '0;
      pend_b      <= '0;
      dac_a_q     <= '0;
      dac_b_q     <= '0;
      dac_a_on_q  <= 1'b0;
      dac_b_on_q  <= 1'b0;
      update_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      pend_a      <= pend_a_nxt;
      pend_b      <= pend_b_nxt;
      frame_err_q <= bad_frame;
      update_q    <= xfer_a | xfer_b;
      if (xfer_a) begin
        dac_a_q    <= gated_code(pend_a_nxt);
        dac_a_on_q <= pend_a_nxt.on;
      end
      if (xfer_b) begin
        dac_b_q    <= gated_code(pend_b_nxt);
        dac_b_on_q <= pend_b_nxt.on;
      end
      case (state)
        IDLE: begin
          if (csn_fall) begin
            shift_q <= '0;
            cnt_q   <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // csn rise wins over a coincident sclk rise: that last edge is dropped.
          if (csn_rise) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], mosi_lvl};
            if (cnt_q != CNT_W'(FRAME_BITS + 1)) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dac_a     = dac_a_q;
  assign bus.dac_b     = dac_b_q;
  assign bus.dac_a_on  = dac_a_on_q;
  assign bus.dac_b_on  = dac_b_on_q;
  assign bus.update    = update_q;
  assign bus.frame_err = frame_err_q;

endmodule
